// File: rtl/ibex_instr_bus_arb_pkg.sv
// Shared types and limits for the instruction-bus arbiter slice.
package ibex_instr_bus_arb_pkg;

  typedef enum logic {
    HOST_IF  = 1'b0,
    HOST_AUX = 1'b1
  } host_id_e;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

endpackage

// File: rtl/ibex_instr_bus_arb_if.sv
// req/gnt/rvalid instruction bus; master issues requests, slave answers them.
interface ibex_instr_bus_arb_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ibex_instr_arb_idq.sv
// In-order source-ID FIFO: remembers which host issued each granted request.
module ibex_instr_arb_idq #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            data_i,
  input  logic            pop_i,
  output logic            head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ibex_instr_bus_arb.sv
// Round-robin arbiter sharing one instruction-memory port between two fetch hosts,
// with in-order response routing via a source-ID queue.
module ibex_instr_bus_arb
  import ibex_instr_bus_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  ibex_instr_bus_arb_if.slave         h0_bus,
  ibex_instr_bus_arb_if.slave         h1_bus,
  ibex_instr_bus_arb_if.master        dev_bus,
  output logic                        busy_o,
  output logic                        spurious_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  host_id_e        sel;
  host_id_e        last_q, last_d;
  host_id_e        lock_sel_q, lock_sel_d;
  logic            lock_q, lock_d;
  logic            spurious_q, spurious_d;
  logic            req_sel, dev_req, grant, resp_ok;
  logic            head, full, empty;
  logic [CntW-1:0] count;

  // A pending un-granted request pins the selection so the address stays stable.
  always_comb begin
    sel = HOST_IF;
    if (lock_q) begin
      sel = lock_sel_q;
    end else begin
      case ({h1_bus.req, h0_bus.req})
        2'b01:   sel = HOST_IF;
        2'b10:   sel = HOST_AUX;
        2'b11:   sel = host_id_e'(~last_q);
        default: sel = HOST_IF;
      endcase
    end
  end

  assign req_sel      = (sel == HOST_AUX) ? h1_bus.req : h0_bus.req;
  assign dev_req      = req_sel & ~full;
  assign grant        = dev_bus.gnt & dev_req;
  assign resp_ok      = dev_bus.rvalid & ~empty;

  assign dev_bus.req  = dev_req;
  assign dev_bus.addr = (sel == HOST_AUX) ? h1_bus.addr : h0_bus.addr;

  assign h0_bus.gnt    = grant & (sel == HOST_IF);
  assign h1_bus.gnt    = grant & (sel == HOST_AUX);
  assign h0_bus.rvalid = resp_ok & ~head;
  assign h1_bus.rvalid = resp_ok & head;
  assign h0_bus.err    = resp_ok & ~head & dev_bus.err;
  assign h1_bus.err    = resp_ok & head & dev_bus.err;
  assign h0_bus.rdata  = dev_bus.rdata;
  assign h1_bus.rdata  = dev_bus.rdata;

  assign busy_o            = (count != '0);
  assign spurious_rvalid_o = spurious_q;

  // Lock drops on grant or when the locked host withdraws its request.
  always_comb begin
    lock_d     = dev_req & ~dev_bus.gnt;
    lock_sel_d = lock_d ? sel : lock_sel_q;
    last_d     = grant ? sel : last_q;
    spurious_d = spurious_q | (dev_bus.rvalid & empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= HOST_IF;
      last_q     <= HOST_AUX;
      spurious_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      last_q     <= last_d;
      spurious_q <= spurious_d;
    end
  end

  ibex_instr_arb_idq #(
    .Depth (MaxOutstanding)
  ) u_idq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (resp_ok),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_ibex_instr_bus_arb.sv
// Directed bench: expected responses queued at grant time, checked when memory answers.
module tb_ibex_instr_bus_arb;

  typedef struct {
    logic        host;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o, spurious_rvalid_o;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t cur;

  always #5 clk_i = ~clk_i;

  ibex_instr_bus_arb_if h0_bus();
  ibex_instr_bus_arb_if h1_bus();
  ibex_instr_bus_arb_if dev_bus();

  ibex_instr_bus_arb #(.MaxOutstanding(2)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .h0_bus            (h0_bus),
    .h1_bus            (h1_bus),
    .dev_bus           (dev_bus),
    .busy_o            (busy_o),
    .spurious_rvalid_o (spurious_rvalid_o)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    h0_bus.req     = 1'b0; h0_bus.addr = '0;
    h1_bus.req     = 1'b0; h1_bus.addr = '0;
    dev_bus.gnt    = 1'b0; dev_bus.rvalid = 1'b0;
    dev_bus.rdata  = '0;   dev_bus.err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_exp(logic host, logic [31:0] data, logic err);
    exp_t e;
    e.host = host; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic resp_drive();
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      cur.host = 1'b0; cur.data = '0; cur.err = 1'b0;
    end else begin
      cur = exp_q.pop_front();
    end
    dev_bus.rvalid = 1'b1;
    dev_bus.rdata  = cur.data;
    dev_bus.err    = cur.err;
  endtask

  task automatic resp_check(string tag);
    chk({tag, "_h0_rvalid"}, 32'(h0_bus.rvalid), 32'(!cur.host));
    chk({tag, "_h1_rvalid"}, 32'(h1_bus.rvalid), 32'(cur.host));
    chk({tag, "_rdata"}, cur.host ? h1_bus.rdata : h0_bus.rdata, cur.data);
    chk({tag, "_h0_err"}, 32'(h0_bus.err), 32'(cur.err & !cur.host));
    chk({tag, "_h1_err"}, 32'(h1_bus.err), 32'(cur.err & cur.host));
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // reset state: everything quiet
    #3;
    chk("rst_dev_req", 32'(dev_bus.req), 0);
    chk("rst_dev_addr", dev_bus.addr, 0);
    chk("rst_gnt", {30'd0, h1_bus.gnt, h0_bus.gnt}, 0);
    chk("rst_rvalid", {30'd0, h1_bus.rvalid, h0_bus.rvalid}, 0);
    chk("rst_err", {30'd0, h1_bus.err, h0_bus.err}, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_spur", 32'(spurious_rvalid_o), 0);

    // single h0 fetch, answered two cycles after the grant
    tick();
    h0_bus.req = 1'b1; h0_bus.addr = 32'h80; dev_bus.gnt = 1'b1;
    #3;
    chk("t1_dev_req", 32'(dev_bus.req), 1);
    chk("t1_dev_addr", dev_bus.addr, 32'h80);
    chk("t1_h0_gnt", 32'(h0_bus.gnt), 1);
    chk("t1_h1_gnt", 32'(h1_bus.gnt), 0);
    chk("t1_busy_pre", 32'(busy_o), 0);
    push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
    tick();
    h0_bus.req = 1'b0; dev_bus.gnt = 1'b0;
    #3;
    chk("t1_h0_gnt_off", 32'(h0_bus.gnt), 0);
    chk("t1_busy_mid", 32'(busy_o), 1);
    tick();
    resp_drive();
    #3;
    resp_check("t1");
    chk("t1_busy_resp", 32'(busy_o), 1);
    tick();
    dev_bus.rvalid = 1'b0;
    #3;
    chk("t1_busy_post", 32'(busy_o), 0);
    chk("t1_rvalid_off", {30'd0, h1_bus.rvalid, h0_bus.rvalid}, 0);

    // both hosts requesting, memory grants every cycle: strict alternation from h0
    do_reset();
    h0_bus.req = 1'b1; h0_bus.addr = 32'h100;
    h1_bus.req = 1'b1; h1_bus.addr = 32'h200;
    dev_bus.gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic host;
      host = i[0];
      if (i > 0) resp_drive();
      else dev_bus.rvalid = 1'b0;
      #3;
      chk($sformatf("t2_h0_gnt%0d", i), 32'(h0_bus.gnt), 32'(!host));
      chk($sformatf("t2_h1_gnt%0d", i), 32'(h1_bus.gnt), 32'(host));
      chk($sformatf("t2_addr%0d", i), dev_bus.addr, host ? 32'h200 : 32'h100);
      if (i > 0) resp_check($sformatf("t2_r%0d", i));
      push_exp(host, 32'hA000_0000 + 32'(i), i == 3);
      tick();
    end
    h0_bus.req = 1'b0; h1_bus.req = 1'b0; dev_bus.gnt = 1'b0;
    resp_drive();
    #3;
    resp_check("t2_drain");
    tick();
    dev_bus.rvalid = 1'b0;

    // h1 stalled by memory; h0 joins but address stays locked on h1
    h1_bus.req = 1'b1; h1_bus.addr = 32'h300;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        h0_bus.req = 1'b1; h0_bus.addr = 32'h400;
      end
      #3;
      chk($sformatf("t3_dev_req%0d", c), 32'(dev_bus.req), 1);
      chk($sformatf("t3_addr%0d", c), dev_bus.addr, 32'h300);
      chk($sformatf("t3_gnt%0d", c), {30'd0, h1_bus.gnt, h0_bus.gnt}, 0);
      tick();
    end
    dev_bus.gnt = 1'b1;
    #3;
    chk("t3_h1_gnt", {30'd0, h1_bus.gnt, h0_bus.gnt}, 32'b10);
    chk("t3_addr_g", dev_bus.addr, 32'h300);
    push_exp(1'b1, 32'h1111_2222, 1'b1);
    tick();
    h1_bus.addr = 32'h304;
    #3;
    chk("t3_h0_next", {30'd0, h1_bus.gnt, h0_bus.gnt}, 32'b01);
    chk("t3_addr_h0", dev_bus.addr, 32'h400);
    push_exp(1'b0, 32'h3333_4444, 1'b0);
    tick();

    // queue full at two: request blocked even with gnt high; pop reopens next cycle
    h0_bus.req = 1'b0;
    #3;
    chk("t4_full_req", 32'(dev_bus.req), 0);
    chk("t4_full_gnt", 32'(h1_bus.gnt), 0);
    chk("t4_busy", 32'(busy_o), 1);
    tick();
    dev_bus.gnt = 1'b0;
    resp_drive();
    #3;
    resp_check("t4_err");
    chk("t4_same_cycle", 32'(dev_bus.req), 0);
    tick();
    dev_bus.rvalid = 1'b0;
    #3;
    chk("t4_reopen", 32'(dev_bus.req), 1);
    chk("t4_addr", dev_bus.addr, 32'h304);
    tick();
    h1_bus.req = 1'b0;
    #3;
    chk("t4_drop", 32'(dev_bus.req), 0);
    tick();
    resp_drive();
    #3;
    resp_check("t4_drain");
    tick();
    dev_bus.rvalid = 1'b0;

    // response with nothing outstanding: dropped and sticky flag set
    #3;
    chk("t5_idle", 32'(busy_o), 0);
    chk("t5_spur_pre", 32'(spurious_rvalid_o), 0);
    tick();
    dev_bus.rvalid = 1'b1; dev_bus.rdata = 32'h5555_5555;
    #3;
    chk("t5_rvalid", {30'd0, h1_bus.rvalid, h0_bus.rvalid}, 0);
    tick();
    dev_bus.rvalid = 1'b0;
    #3;
    chk("t5_spur", 32'(spurious_rvalid_o), 1);
    tick(); tick(); tick();
    #3;
    chk("t5_spur_sticky", 32'(spurious_rvalid_o), 1);

    // reset with two in flight: busy drops at once, late answer is spurious
    do_reset();
    #3;
    chk("t6_spur_clr", 32'(spurious_rvalid_o), 0);
    tick();
    h0_bus.req = 1'b1; h0_bus.addr = 32'h500; dev_bus.gnt = 1'b1;
    tick();
    tick();
    h0_bus.req = 1'b0; dev_bus.gnt = 1'b0;
    #3;
    chk("t6_busy", 32'(busy_o), 1);
    chk("t6_full", 32'(dev_bus.req), 0);
    rst_ni = 1'b0;
    #1;
    chk("t6_busy_rst", 32'(busy_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    dev_bus.rvalid = 1'b1; dev_bus.rdata = 32'h6666_6666;
    #3;
    chk("t6_late_rv", {30'd0, h1_bus.rvalid, h0_bus.rvalid}, 0);
    tick();
    dev_bus.rvalid = 1'b0;
    #3;
    chk("t6_late_spur", 32'(spurious_rvalid_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
